// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment bit map, decode table and scan state encoding.
package seg_pkg;

  localparam int SEG_DOT = 0;
  localparam int SEG_G   = 1;
  localparam int SEG_F   = 2;
  localparam int SEG_E   = 3;
  localparam int SEG_D   = 4;
  localparam int SEG_C   = 5;
  localparam int SEG_B   = 6;
  localparam int SEG_A   = 7;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // a..g, a in bit 6; codes 10-15 are dark
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  typedef enum logic [1:0] {
    OFF,
    BLANK,
    SHOW
  } scan_state_t;

  function automatic logic [7:0] seg_pack(
    input logic [6:0] abcdefg,
    input logic       dot
  );
    logic [7:0] p;
    p[SEG_A]   = ~abcdefg[6];
    p[SEG_B]   = ~abcdefg[5];
    p[SEG_C]   = ~abcdefg[4];
    p[SEG_D]   = ~abcdefg[3];
    p[SEG_E]   = ~abcdefg[2];
    p[SEG_F]   = ~abcdefg[1];
    p[SEG_G]   = ~abcdefg[0];
    p[SEG_DOT] = ~dot;
    return p;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Datapath-to-display bundle for the scan controller.
// master drives codes and controls; slave drives the pins.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  enableIn;
  logic [4*DIGITS-1:0]   valueIn;
  logic [DIGITS-1:0]     dotMaskIn;
  logic                  blankLeadingIn;
  logic                  loadIn;
  logic [7:0]            segmentEnable;
  logic [DIGITS-1:0]     digitEnable;
  logic                  frameDone;

  modport master (
    output enableIn,
    output valueIn,
    output dotMaskIn,
    output blankLeadingIn,
    output loadIn,
    input  segmentEnable,
    input  digitEnable,
    input  frameDone
  );

  modport slave (
    input  enableIn,
    input  valueIn,
    input  dotMaskIn,
    input  blankLeadingIn,
    input  loadIn,
    output segmentEnable,
    output digitEnable,
    output frameDone
  );
endinterface

// File: rtl/seg_scan_ctrl_decoder.sv
// BCD to active-high a..g segment decoder with blank override.
// Shared with the single-digit display logic.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[code];
    if (blank) seg = 7'b0000000;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode scan controller with blanking gap,
// leading-zero suppression and frame-synchronous loading.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DWELL_CYCLES = 27000,
  parameter int BLANK_CYCLES = 270
) (
  input logic       clkIn,
  input logic       resetIn,
  seg_scan_if.slave bus
);

  localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IW-1:0] LAST   = IW'(DIGITS - 1);
  localparam logic [TW-1:0] T_DWL  = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] T_BLK  = TW'(BLANK_CYCLES - 1);

  scan_state_t state, state_n;

  logic [IW-1:0]          idx, idx_n;
  logic [TW-1:0]          tmr, tmr_n;
  logic [DIGITS-1:0][3:0] shd_val, shd_val_n;
  logic [DIGITS-1:0][3:0] act_val, act_val_n;
  logic [DIGITS-1:0]      shd_dot, shd_dot_n;
  logic [DIGITS-1:0]      act_dot, act_dot_n;
  logic                   pend, pend_n;
  logic                   frame_end;

  logic [DIGITS-1:0]      lead;
  logic                   blank;
  logic [6:0]             dec;
  logic [7:0]             seg_n;
  logic [DIGITS-1:0]      dig_n;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    tmr_n     = tmr;
    frame_end = 1'b0;
    if (!bus.enableIn) begin
      state_n = OFF;
      idx_n   = '0;
      tmr_n   = '0;
    end else begin
      unique case (state)
        OFF: begin
          state_n = BLANK;
          idx_n   = '0;
          tmr_n   = '0;
        end
        BLANK: begin
          if (tmr == T_BLK) begin
            state_n = SHOW;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr + TW'(1);
          end
        end
        SHOW: begin
          if (tmr == T_DWL) begin
            state_n   = BLANK;
            tmr_n     = '0;
            frame_end = (idx == LAST);
            idx_n     = (idx == LAST) ? '0 : idx + IW'(1);
          end else begin
            tmr_n = tmr + TW'(1);
          end
        end
        default: begin
          state_n = OFF;
          idx_n   = '0;
          tmr_n   = '0;
        end
      endcase
    end
  end

  // Active only changes at frame end or while dark, so no tearing.
  always_comb begin
    shd_val_n = shd_val;
    shd_dot_n = shd_dot;
    act_val_n = act_val;
    act_dot_n = act_dot;
    pend_n    = pend;
    if (frame_end && pend) begin
      act_val_n = shd_val;
      act_dot_n = shd_dot;
      pend_n    = 1'b0;
    end
    if (bus.loadIn) begin
      shd_val_n = bus.valueIn;
      shd_dot_n = bus.dotMaskIn;
      if (state == OFF || frame_end) begin
        act_val_n = bus.valueIn;
        act_dot_n = bus.dotMaskIn;
        pend_n    = 1'b0;
      end else begin
        pend_n = 1'b1;
      end
    end
  end

  always_comb begin
    lead = '0;
    lead[DIGITS-1] = (act_val[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lead[i] = lead[i+1] && (act_val[i] == 4'd0);
    end
  end

  assign blank = bus.blankLeadingIn &&
                 (idx_n != '0) && lead[idx_n];

  seg_decoder u_dec (
    .code  (act_val[idx_n]),
    .blank (blank),
    .seg   (dec)
  );

  // Outputs follow the next state so enable and segments move together.
  always_comb begin
    seg_n = SEG_OFF;
    dig_n = '1;
    if (state_n == SHOW) begin
      dig_n[idx_n] = 1'b0;
      seg_n        = seg_pack(dec, act_dot[idx_n]);
    end
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state             <= OFF;
      idx               <= '0;
      tmr               <= '0;
      shd_val           <= '0;
      shd_dot           <= '0;
      act_val           <= '0;
      act_dot           <= '0;
      pend              <= 1'b0;
      bus.segmentEnable <= SEG_OFF;
      bus.digitEnable   <= '1;
      bus.frameDone     <= 1'b0;
    end else begin
      state             <= state_n;
      idx               <= idx_n;
      tmr               <= tmr_n;
      shd_val           <= shd_val_n;
      shd_dot           <= shd_dot_n;
      act_val           <= act_val_n;
      act_dot           <= act_dot_n;
      pend              <= pend_n;
      bus.segmentEnable <= seg_n;
      bus.digitEnable   <= dig_n;
      bus.frameDone     <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scan controller bench: randomized stimulus against a
// position-in-frame reference model.
module tb_seg_scan_ctrl;

  localparam int D   = 4;
  localparam int DW  = 4;
  localparam int BL  = 1;
  localparam int SL  = DW + BL;
  localparam int PER = D * SL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seg_scan_if #(.DIGITS(D)) bus ();

  seg_scan_ctrl #(
    .DIGITS       (D),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .clkIn   (clk),
    .resetIn (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // pos: clocks since scanning began (-1 = dark/off)
  int          pos;
  logic [15:0] m_act, m_shd;
  logic [3:0]  m_dact, m_dshd;
  bit          m_pend, m_fd;

  always @(negedge clk) begin
    checks++;
    assert ($countones(~bus.digitEnable) <= 1)
    else begin
      errors++;
      $display("FAIL onehot: digitEnable=%b", bus.digitEnable);
    end
  end

  function automatic logic [6:0] ref_dec(input logic [3:0] c);
    case (c)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_reset();
    pos    = -1;
    m_act  = '0;
    m_shd  = '0;
    m_dact = '0;
    m_dshd = '0;
    m_pend = 1'b0;
    m_fd   = 1'b0;
  endtask

  task automatic step();
    bit fe, was_off;
    @(posedge clk);
    was_off = (pos < 0);
    fe = 1'b0;
    if (!bus.enableIn) begin
      pos = -1;
    end else begin
      pos = pos + 1;
      fe  = (pos > 0) && (pos % PER == 0);
    end
    if (fe && m_pend) begin
      m_act  = m_shd;
      m_dact = m_dshd;
      m_pend = 1'b0;
    end
    if (bus.loadIn) begin
      m_shd  = bus.valueIn;
      m_dshd = bus.dotMaskIn;
      if (was_off || fe) begin
        m_act  = bus.valueIn;
        m_dact = bus.dotMaskIn;
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end
    m_fd = fe;
    #1;
  endtask

  function automatic logic [12:0] model_out();
    int d, q, r;
    logic [7:0] s;
    logic [3:0] g;
    bit blk;
    s = 8'hFF;
    g = 4'hF;
    if (pos >= 0) begin
      q = pos % PER;
      d = q / SL;
      r = q % SL;
      if (r >= BL) begin
        g   = ~(4'b0001 << d);
        blk = bus.blankLeadingIn && d > 0 &&
              ((m_act >> (4 * d)) == 16'd0);
        s   = {blk ? 7'h7F : ~ref_dec(m_act[4*d+:4]),
               ~m_dact[d]};
      end
    end
    return {s, g, m_fd};
  endfunction

  function automatic logic [12:0] dut_out();
    return {bus.segmentEnable, bus.digitEnable, bus.frameDone};
  endfunction

  function automatic bit lit_digit(input int d);
    return pos >= 0 && (pos % PER) / SL == d && (pos % SL) >= BL;
  endfunction

  task automatic test_reset();
    logic [12:0] got, exp;
    #12;
    checks++;
    if (bus.segmentEnable !== 8'hFF) begin
      errors++;
      $display("FAIL reset_seg: got %h want ff", bus.segmentEnable);
    end
    checks++;
    if (bus.digitEnable !== 4'hF) begin
      errors++;
      $display("FAIL reset_dig: got %b want 1111", bus.digitEnable);
    end
    checks++;
    if (bus.frameDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_fd: got %b want 0", bus.frameDone);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_idle c%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_scan();
    logic [12:0] got, exp;
    int last, nfd;
    logic [7:0] want;
    bus.enableIn  = 1'b1;
    bus.valueIn   = 16'h1234;
    bus.dotMaskIn = 4'b0000;
    bus.loadIn    = 1'b1;
    last = -1;
    nfd  = 0;
    for (int i = 0; i < 65; i++) begin
      step();
      bus.loadIn = 1'b0;
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL scan c%0d: got %h want %h", i, got, exp);
      end
      unique case (bus.digitEnable)
        4'b1110: want = 8'h99;
        4'b1101: want = 8'h0D;
        4'b1011: want = 8'h25;
        4'b0111: want = 8'h9F;
        default: want = 8'hFF;
      endcase
      checks++;
      if (bus.segmentEnable !== want) begin
        errors++;
        $display("FAIL scan_const c%0d: got %h want %h",
                 i, bus.segmentEnable, want);
      end
      if (bus.frameDone) begin
        nfd++;
        if (last >= 0) begin
          checks++;
          if (i - last != PER) begin
            errors++;
            $display("FAIL scan_period: got %0d want %0d",
                     i - last, PER);
          end
        end
        last = i;
      end
    end
    checks++;
    if (nfd < 3) begin
      errors++;
      $display("FAIL scan_fd_count: got %0d want 3", nfd);
    end
  endtask

  task automatic test_blank();
    logic [12:0] got, exp;
    bit seen;
    bus.valueIn        = 16'h0007;
    bus.blankLeadingIn = 1'b1;
    bus.loadIn         = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step();
      bus.loadIn = 1'b0;
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL blank c%0d: got %h want %h", i, got, exp);
      end
      if (bus.frameDone) seen = 1'b1;
      if (seen && bus.digitEnable != 4'hF) begin
        checks++;
        if (bus.segmentEnable !==
            ((bus.digitEnable == 4'b1110) ? 8'h1F : 8'hFF)) begin
          errors++;
          $display("FAIL blank_const c%0d: dig %b seg %h",
                   i, bus.digitEnable, bus.segmentEnable);
        end
      end
    end
    bus.blankLeadingIn = 1'b0;
  endtask

  task automatic test_midload();
    logic [12:0] got, exp;
    bit found, seen;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = lit_digit(1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midload_wait: digit1 not reached");
    end
    bus.valueIn = 16'h5678;
    bus.loadIn  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      bus.loadIn = 1'b0;
      if (i == 2) begin
        bus.valueIn = 16'h4321;
        bus.loadIn  = 1'b1;
      end
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL midload c%0d: got %h want %h", i, got, exp);
      end
      if (bus.frameDone) seen = 1'b1;
      if (bus.digitEnable == 4'b1110) begin
        checks++;
        if (bus.segmentEnable !== (seen ? 8'h9F : 8'h1F)) begin
          errors++;
          $display("FAIL midload_d0 c%0d: got %h seen=%0d",
                   i, bus.segmentEnable, seen);
        end
      end
    end
  endtask

  task automatic test_dots();
    logic [12:0] got, exp;
    bit seen;
    bus.valueIn   = 16'h1234;
    bus.dotMaskIn = 4'b0100;
    bus.loadIn    = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step();
      bus.loadIn = 1'b0;
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL dots c%0d: got %h want %h", i, got, exp);
      end
      if (bus.frameDone) seen = 1'b1;
      if (seen) begin
        checks++;
        if (bus.segmentEnable[0] !== (bus.digitEnable != 4'b1011)) begin
          errors++;
          $display("FAIL dots_const c%0d: dig %b dot %b",
                   i, bus.digitEnable, bus.segmentEnable[0]);
        end
      end
    end
    bus.dotMaskIn = 4'b0000;
    bus.loadIn    = 1'b1;
  endtask

  task automatic test_code_c();
    logic [12:0] got, exp;
    bit seen;
    bus.valueIn = 16'h00C5;
    bus.loadIn  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step();
      bus.loadIn = 1'b0;
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL code_c c%0d: got %h want %h", i, got, exp);
      end
      if (bus.frameDone) seen = 1'b1;
      if (seen && bus.digitEnable == 4'b1101) begin
        checks++;
        if (bus.segmentEnable !== 8'hFF) begin
          errors++;
          $display("FAIL code_c_const: got %h want ff",
                   bus.segmentEnable);
        end
      end
    end
  endtask

  task automatic test_disable();
    logic [12:0] got, exp;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = lit_digit(2);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL disable_wait: digit2 not reached");
    end
    bus.enableIn = 1'b0;
    step();
    checks++;
    if (dut_out() !== {8'hFF, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL disable_dark: got %h want 1ffe", dut_out());
    end
    bus.enableIn = 1'b1;
    step();
    checks++;
    if (bus.digitEnable !== 4'hF) begin
      errors++;
      $display("FAIL reenable_blank: got %b want 1111",
               bus.digitEnable);
    end
    step();
    checks++;
    if (bus.digitEnable !== 4'b1110) begin
      errors++;
      $display("FAIL reenable_d0: got %b want 1110",
               bus.digitEnable);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL disable c%0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] got, exp;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = lit_digit(1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL areset_wait: no lit digit");
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.segmentEnable !== 8'hFF || bus.digitEnable !== 4'hF) begin
      errors++;
      $display("FAIL areset_now: got %h/%b want ff/1111",
               bus.segmentEnable, bus.digitEnable);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL areset c%0d: got %h want %h", i, got, exp);
      end
      if (bus.digitEnable == 4'b1110) begin
        checks++;
        if (bus.segmentEnable !== 8'h03) begin
          errors++;
          $display("FAIL areset_zero: got %h want 03",
                   bus.segmentEnable);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] got, exp;
    logic [15:0] v;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++) begin
        v[4*k+:4] = ($urandom_range(0, 2) == 0) ?
                    4'd0 : 4'($urandom_range(0, 15));
      end
      bus.valueIn   = v;
      bus.dotMaskIn = 4'($urandom_range(0, 15));
      bus.loadIn    = ($urandom_range(0, 6) == 0);
      bus.enableIn  = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 15) == 0)
        bus.blankLeadingIn = ~bus.blankLeadingIn;
      step();
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random c%0d: got %h want %h", i, got, exp);
      end
    end
    bus.loadIn   = 1'b0;
    bus.enableIn = 1'b1;
  endtask

  initial begin
    bus.enableIn       = 1'b0;
    bus.valueIn        = '0;
    bus.dotMaskIn      = '0;
    bus.blankLeadingIn = 1'b0;
    bus.loadIn         = 1'b0;
    model_reset();
    test_reset();
    test_scan();
    test_blank();
    test_midload();
    test_dots();
    test_code_c();
    test_disable();
    test_random();
    bus.blankLeadingIn = 1'b0;
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
